// File: rtl/phy_regfile_read_stage.sv
// Register-read stage: physical register file plus ready scoreboard, feeding a
// single-entry issue register with writeback bypass and wakeup snoop while stalled.
module phy_regfile_read_stage #(
    parameter int PHY_REG_NUM = 64,
    parameter int PHY_REG_W   = 6,
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int IMM_W       = 32,
    parameter int TAG_W       = 5,
    parameter int CTRL_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [CTRL_W-1:0]    in_control,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PHY_REG_W-1:0] in_rs1,
    input  logic [PHY_REG_W-1:0] in_rs2,
    input  logic [PHY_REG_W-1:0] in_rd,
    input  logic [IMM_W-1:0]     in_imm,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 in_ready,
    input  logic                 wb_valid,
    input  logic [PHY_REG_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [CTRL_W-1:0]    out_control,
    output logic [PC_W-1:0]      out_pc,
    output logic [IMM_W-1:0]     out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic [PHY_REG_W-1:0] out_rd,
    output logic [DATA_W-1:0]    out_rs1_data,
    output logic [DATA_W-1:0]    out_rs2_data,
    output logic                 out_rs1_rdy,
    output logic                 out_rs2_rdy,
    output logic [PHY_REG_W-1:0] out_rs1,
    output logic [PHY_REG_W-1:0] out_rs2,
    input  logic                 out_ready
);

    logic [DATA_W-1:0]      regs [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0] sb;
    logic                   wb_en;
    logic                   accept;
    logic [DATA_W-1:0]      rs1_data_p0, rs2_data_p0;
    logic                   rs1_rdy_p0, rs2_rdy_p0;

    assign wb_en    = wb_valid && (wb_reg != '0);
    assign in_ready = (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // p0 is hardwired; a same-cycle writeback overrides the stale array value
    always_comb begin
        rs1_data_p0 = regs[in_rs1];
        rs1_rdy_p0  = sb[in_rs1];
        if (wb_en && wb_reg == in_rs1) begin
            rs1_data_p0 = wb_data;
            rs1_rdy_p0  = 1'b1;
        end
        if (in_rs1 == '0) begin
            rs1_data_p0 = '0;
            rs1_rdy_p0  = 1'b1;
        end
        rs2_data_p0 = regs[in_rs2];
        rs2_rdy_p0  = sb[in_rs2];
        if (wb_en && wb_reg == in_rs2) begin
            rs2_data_p0 = wb_data;
            rs2_rdy_p0  = 1'b1;
        end
        if (in_rs2 == '0) begin
            rs2_data_p0 = '0;
            rs2_rdy_p0  = 1'b1;
        end
    end

    // Busy-marking of the new destination is ordered after the writeback so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHY_REG_NUM; i++) regs[i] <= '0;
            sb <= '1;
        end else begin
            if (wb_en) begin
                regs[wb_reg] <= wb_data;
                sb[wb_reg]   <= 1'b1;
            end
            if (accept && in_rd != '0) sb[in_rd] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            out_valid <= 1'b0;
        else if (flush)        out_valid <= 1'b0;
        else if (accept)       out_valid <= 1'b1;
        else if (out_ready)    out_valid <= 1'b0;
    end

    // Issue payload: loaded on accept, otherwise only woken-up sources change
    always_ff @(posedge clk) begin
        if (accept) begin
            out_control  <= in_control;
            out_pc       <= in_pc;
            out_imm      <= in_imm;
            out_tag      <= in_tag;
            out_rd       <= in_rd;
            out_rs1      <= in_rs1;
            out_rs2      <= in_rs2;
            out_rs1_data <= rs1_data_p0;
            out_rs2_data <= rs2_data_p0;
            out_rs1_rdy  <= rs1_rdy_p0;
            out_rs2_rdy  <= rs2_rdy_p0;
        end else if (out_valid) begin
            if (wb_en && wb_reg == out_rs1 && !out_rs1_rdy) begin
                out_rs1_data <= wb_data;
                out_rs1_rdy  <= 1'b1;
            end
            if (wb_en && wb_reg == out_rs2 && !out_rs2_rdy) begin
                out_rs2_data <= wb_data;
                out_rs2_rdy  <= 1'b1;
            end
        end
    end

endmodule
